// File: rtl/bfp_expand.sv
// bfp_expand -- block-floating-point expander.
//
// Frames of narrow signed fixed-point samples that share one exponent are
// restored to a wide signed fixed-point format. Each sample is realigned
// to the output binary point, shifted left by the frame exponent, and
// saturated to the output width. Samples that saturate are flagged.
//
// Ports:
//   clk          single clock
//   rst          asynchronous, active-high reset
//   exp          frame exponent (left-shift amount), unsigned
//   exp_valid    exponent strobe; accepted only between frames
//   din          input sample, signed, DIN_POINT fractional bits
//   din_valid    sample strobe
//   dout         expanded sample, signed, DOUT_POINT fractional bits
//   dout_valid   dout strobe; two cycles after din_valid
//   frame_start  high with dout_valid on the first sample of a frame
//   warning      0 ok, 1 positive saturation, 2 negative saturation
//   frame_err    one-cycle pulse on a protocol error (stray sample or
//                stray exponent)
module bfp_expand #(
    parameter int DIN_WIDTH  = 8,
    parameter int DIN_POINT  = 7,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_POINT = 10,
    parameter int EXP_WIDTH  = 4,
    parameter int FRAME_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXP_WIDTH-1:0]  exp,
    input  logic                  exp_valid,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  frame_start,
    output logic [1:0]            warning,
    output logic                  frame_err
);

    localparam int PAD   = DOUT_POINT - DIN_POINT;
    // Wide enough that the largest shift never drops a significant bit.
    localparam int W     = DIN_WIDTH + PAD + (2 ** EXP_WIDTH) - 1;
    // Comparison width: holds both the shifted value and the output limits.
    localparam int XW    = ((W > DOUT_WIDTH) ? W : DOUT_WIDTH) + 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    localparam logic signed [XW-1:0] SAT_MAX =
        {{(XW - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN =
        {{(XW - DOUT_WIDTH + 1){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

    // Returns {warning, dout}.
    function automatic logic [DOUT_WIDTH+1:0] saturate(input logic signed [W-1:0] s);
        logic signed [XW-1:0] sx;
        sx = XW'(s);
        if (sx > SAT_MAX)
            return {2'd1, SAT_MAX[DOUT_WIDTH-1:0]};
        else if (sx < SAT_MIN)
            return {2'd2, SAT_MIN[DOUT_WIDTH-1:0]};
        else
            return {2'd0, sx[DOUT_WIDTH-1:0]};
    endfunction

    typedef enum logic {WAIT_EXP, RUN} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [EXP_WIDTH-1:0] exp_q, exp_nx;
    logic [EXP_WIDTH-1:0] shift_amt;
    logic                 accept;
    logic                 first;
    logic                 err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_EXP;
            cnt   <= '0;
            exp_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            exp_q <= exp_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        exp_nx    = exp_q;
        shift_amt = exp_q;
        accept    = 1'b0;
        first     = 1'b0;
        err       = 1'b0;
        case (state)
            WAIT_EXP: begin
                // A sample arriving with its exponent uses it immediately.
                shift_amt = exp;
                if (exp_valid) begin
                    exp_nx   = exp;
                    cnt_nx   = '0;
                    state_nx = RUN;
                    if (din_valid) begin
                        accept = 1'b1;
                        first  = 1'b1;
                        if (FRAME_LEN == 1)
                            state_nx = WAIT_EXP;
                        else
                            cnt_nx = CNT_W'(1);
                    end
                end else if (din_valid) begin
                    err = 1'b1;
                end
            end
            RUN: begin
                err = exp_valid;
                if (din_valid) begin
                    accept = 1'b1;
                    first  = (cnt == '0);
                    if (cnt == LAST) begin
                        state_nx = WAIT_EXP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = WAIT_EXP;
        endcase
    end

    // Stage 1: align to the output binary point and apply the exponent.
    logic signed [DIN_WIDTH-1:0] din_s;
    logic signed [W-1:0]         aligned;
    logic signed [W-1:0]         shifted_p1;
    logic                        vld_p1;
    logic                        first_p1;

    assign din_s   = din;
    assign aligned = W'(din_s) <<< PAD;

    always_ff @(posedge clk) begin
        if (accept)
            shifted_p1 <= aligned <<< shift_amt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vld_p1    <= accept;
            first_p1  <= first;
            frame_err <= err;
        end
    end

    // Stage 2: saturate and register outputs; dout/warning hold between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            dout        <= '0;
            warning     <= 2'd0;
        end else begin
            dout_valid  <= vld_p1;
            frame_start <= vld_p1 & first_p1;
            if (vld_p1)
                {warning, dout} <= saturate(shifted_p1);
        end
    end

endmodule

// File: tb/tb_bfp_expand.sv
// Testbench for bfp_expand: directed and randomised stimulus checked against
// an arithmetic reference model (value = din * 2^(frac shift + exp), clipped).
module tb_bfp_expand;

    localparam int PAD = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  exp;
    logic        exp_valid;
    logic [7:0]  din;
    logic        din_valid;

    logic [15:0] a_dout, b_dout;
    logic        a_vld, b_vld, a_fs, b_fs, a_err, b_err;
    logic [1:0]  a_warn, b_warn;

    bfp_expand dut_a (
        .clk(clk), .rst(rst), .exp(exp), .exp_valid(exp_valid),
        .din(din), .din_valid(din_valid), .dout(a_dout), .dout_valid(a_vld),
        .frame_start(a_fs), .warning(a_warn), .frame_err(a_err)
    );

    bfp_expand #(.FRAME_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .exp(exp), .exp_valid(exp_valid),
        .din(din), .din_valid(din_valid), .dout(b_dout), .dout_valid(b_vld),
        .frame_start(b_fs), .warning(b_warn), .frame_err(b_err)
    );

    bit          sel_b;
    logic [15:0] obs_dout;
    logic        obs_vld, obs_fs, obs_err;
    logic [1:0]  obs_warn;
    assign obs_dout = sel_b ? b_dout : a_dout;
    assign obs_vld  = sel_b ? b_vld  : a_vld;
    assign obs_fs   = sel_b ? b_fs   : a_fs;
    assign obs_err  = sel_b ? b_err  : a_err;
    assign obs_warn = sel_b ? b_warn : a_warn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        fs;
        logic        err;
        logic [15:0] dout;
        logic [1:0]  warn;
    } res_t;

    int   npass = 0;
    int   ntot  = 0;
    int   nfail = 0;

    // Reference model state: inside a frame or not, samples taken, frame exponent.
    bit   m_run;
    int   m_cnt;
    int   m_exp;
    res_t pend;
    logic [15:0] hold_dout;
    logic [1:0]  hold_warn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit dv, input logic [7:0] d, input bit ev,
                         input logic [3:0] e, output res_t r);
        longint v;
        int fl;
        fl = sel_b ? 4 : 64;
        r = '0;
        if (!m_run) begin
            if (ev) begin
                m_exp = int'(e);
                m_run = 1'b1;
                m_cnt = 0;
            end else if (dv) begin
                r.err = 1'b1;
            end
        end else if (ev) begin
            r.err = 1'b1;
        end
        if (m_run && dv) begin
            r.valid = 1'b1;
            r.fs    = (m_cnt == 0);
            v = longint'($signed(d)) * (longint'(1) << (PAD + m_exp));
            if (v > 32767) begin
                r.dout = 16'h7FFF; r.warn = 2'd1;
            end else if (v < -32768) begin
                r.dout = 16'h8000; r.warn = 2'd2;
            end else begin
                r.dout = 16'(v);   r.warn = 2'd0;
            end
            m_cnt++;
            if (m_cnt == fl) begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input bit dv, input logic [7:0] d, input bit ev, input logic [3:0] e);
        res_t r;
        din_valid = dv;
        din       = d;
        exp_valid = ev;
        exp       = e;
        model(dv, d, ev, e, r);
        @(posedge clk);
        #1;
        check("frame_err", 32'(obs_err), 32'(r.err));
        check("dout_valid", 32'(obs_vld), 32'(pend.valid));
        if (pend.valid) begin
            check("dout", 32'(obs_dout), 32'(pend.dout));
            check("warning", 32'(obs_warn), 32'(pend.warn));
            check("frame_start", 32'(obs_fs), 32'(pend.fs));
            hold_dout = pend.dout;
            hold_warn = pend.warn;
        end else begin
            check("dout_hold", 32'(obs_dout), 32'(hold_dout));
            check("warning_hold", 32'(obs_warn), 32'(hold_warn));
            check("frame_start_idle", 32'(obs_fs), 32'd0);
        end
        pend = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_dout", 32'(obs_dout), 32'd0);
        check("rst_dout_valid", 32'(obs_vld), 32'd0);
        check("rst_warning", 32'(obs_warn), 32'd0);
        check("rst_frame_start", 32'(obs_fs), 32'd0);
        check("rst_frame_err", 32'(obs_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_run = 1'b0;
        m_cnt = 0;
        m_exp = 0;
        pend = '0;
        hold_dout = '0;
        hold_warn = '0;
    endtask

    // Start a frame with its exponent on the first sample, then fill it.
    task automatic run_frame(input logic [3:0] e, input logic [7:0] first_d, input logic [7:0] fill);
        step(1'b1, first_d, 1'b1, e);
        for (int i = 0; i < 64 && m_run; i++) step(1'b1, fill, 1'b0, 4'h0);
    endtask

    initial begin
        rst = 1'b0;
        din_valid = 1'b0;
        exp_valid = 1'b0;
        din = '0;
        exp = '0;
        sel_b = 1'b0;
        #2;
        do_reset();

        // Nominal frame: 0x40 at exp 3 -> 0x1000, then 0x20 -> 0x0800.
        run_frame(4'd3, 8'h40, 8'h20);
        idle(2);

        // Saturation corners.
        run_frame(4'd15, 8'h7F, 8'h01);
        run_frame(4'd5, 8'h80, 8'hFF);
        run_frame(4'd6, 8'h80, 8'h7F);
        idle(2);

        // Stray sample between frames is dropped.
        step(1'b1, 8'h11, 1'b0, 4'h0);
        idle(2);

        // Stray exponent mid-frame: flagged and ignored.
        step(1'b1, 8'h10, 1'b1, 4'd1);
        step(1'b1, 8'h10, 1'b0, 4'd0);
        step(1'b1, 8'h10, 1'b1, 4'd9);
        step(1'b1, 8'h10, 1'b0, 4'd0);
        step(1'b1, 8'hF0, 1'b0, 4'd0);
        for (int i = 0; i < 64 && m_run; i++) step(1'b1, 8'($urandom), 1'b0, 4'h0);
        idle(2);

        // Reset mid-frame: in-flight samples vanish, next stray sample is dropped.
        step(1'b1, 8'h30, 1'b1, 4'd2);
        for (int i = 0; i < 9; i++) step(1'b1, 8'h30, 1'b0, 4'h0);
        do_reset();
        step(1'b1, 8'h33, 1'b0, 4'h0);
        idle(3);

        // Randomised sweep on the 64-sample configuration.
        for (int i = 0; i < 600; i++) begin
            bit dv, ev;
            dv = ($urandom_range(0, 3) != 0);
            ev = m_run ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
            step(dv, 8'($urandom), ev, 4'($urandom));
        end
        idle(2);

        // Back-to-back short frames, exponent alternating 0/2.
        sel_b = 1'b1;
        do_reset();
        for (int f = 0; f < 6; f++)
            for (int k = 0; k < 4; k++)
                step(1'b1, 8'($urandom), (k == 0), (f % 2 == 1) ? 4'd2 : 4'd0);
        // Exponent arriving with the last sample of a frame is rejected.
        step(1'b1, 8'h21, 1'b1, 4'd1);
        step(1'b1, 8'h22, 1'b0, 4'd0);
        step(1'b1, 8'h23, 1'b0, 4'd0);
        step(1'b1, 8'h24, 1'b1, 4'd7);
        step(1'b1, 8'h25, 1'b0, 4'd0);
        step(1'b1, 8'h26, 1'b1, 4'd4);
        for (int i = 0; i < 200; i++) begin
            bit dv, ev;
            dv = ($urandom_range(0, 3) != 0);
            ev = m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            step(dv, 8'($urandom), ev, 4'($urandom));
        end
        idle(3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
